// File: rtl/jtpopeye_objline.sv
// Double-buffered object line buffer: keeps the objects that cross the next line in the fill bank
// while the renderer reads the previous line's objects from the scan bank.
module jtpopeye_objline #(
    parameter int unsigned DW = 18,
    parameter int unsigned AW = 6,
    parameter int unsigned VW = 8,
    parameter int unsigned HW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          line_start,
    input  logic [VW-1:0] vpos,
    input  logic          wr_en,
    input  logic [VW-1:0] wr_ypos,
    input  logic          wr_vflip,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic [HW-1:0] rd_row,
    output logic          rd_valid,
    output logic [AW:0]   scan_count,
    output logic          overflow
);

    localparam int unsigned DEPTH = 2**AW;
    localparam int unsigned MW    = HW + DW;
    localparam int unsigned CW    = AW + 1;

    logic          fill_bank;
    logic [AW:0]   fill_cnt;
    logic          ovf_int;
    logic          rd_sel;
    logic [MW-1:0] mem0 [DEPTH];
    logic [MW-1:0] mem1 [DEPTH];
    logic [MW-1:0] q0, q1, rd_word;

    logic [VW-1:0] sum;
    logic          visible;
    logic [HW-1:0] row;
    logic [AW:0]   cnt_base;
    logic [AW:0]   scan_cnt_eff;
    logic          room, do_fill, do_wr, wr_bank, rd_bank;
    logic [AW-1:0] wr_addr;

    // A swap in the same cen takes effect before the write and the read are resolved
    always_comb begin
        sum          = vpos + wr_ypos + VW'(1);
        visible      = (sum[VW-1:HW] == '0);
        row          = sum[HW-1:0] ^ {HW{wr_vflip}};
        cnt_base     = line_start ? '0 : fill_cnt;
        scan_cnt_eff = line_start ? fill_cnt : scan_count;
        room         = (cnt_base < CW'(DEPTH));
        do_fill      = cen && wr_en && visible;
        do_wr        = do_fill && room;
        wr_bank      = line_start ? ~fill_bank : fill_bank;
        rd_bank      = ~wr_bank;
        wr_addr      = cnt_base[AW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_bank  <= 1'b0;
            fill_cnt   <= '0;
            ovf_int    <= 1'b0;
            scan_count <= '0;
            overflow   <= 1'b0;
            rd_valid   <= 1'b0;
            rd_sel     <= 1'b0;
        end else if (cen) begin
            if (line_start) begin
                fill_bank  <= ~fill_bank;
                scan_count <= fill_cnt;
                overflow   <= ovf_int;
            end
            fill_cnt <= cnt_base + (do_wr ? CW'(1) : CW'(0));
            ovf_int  <= (ovf_int && !line_start) || (do_fill && !room);
            rd_valid <= ({1'b0, rd_addr} < scan_cnt_eff);
            rd_sel   <= rd_bank;
        end
    end

    // One inferred RAM per bank, each with a registered read port
    always_ff @(posedge clk) begin
        if (cen) begin
            if (do_wr && !wr_bank) mem0[wr_addr] <= {row, wr_data};
            q0 <= mem0[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (cen) begin
            if (do_wr && wr_bank) mem1[wr_addr] <= {row, wr_data};
            q1 <= mem1[rd_addr];
        end
    end

    always_comb begin
        rd_word = rd_sel ? q1 : q0;
        rd_data = rd_valid ? rd_word[DW-1:0]  : '0;
        rd_row  = rd_valid ? rd_word[MW-1:DW] : '0;
    end

endmodule
